// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
//   Shared definitions for the single-cycle MIPS-I integer subset core:
//   opcode and funct encodings, the ALU operation enum, and the decoded
//   control bundle passed from the decoder to the datapath.
//
//   Optional feature macro: MIPS_SHIFT_EN (enables sll/srl decoding in
//   mips_alu_core). The encodings below are always defined.
// ---------------------------------------------------------------------------
package mips_pkg;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes (instr[5:0])
  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  // ALU_ZERO is what undecodable instructions select, so their visible
  // ALU result is 0.
  typedef enum logic [3:0] {
    ALU_ZERO = 4'd0,
    ALU_ADD  = 4'd1,
    ALU_SUB  = 4'd2,
    ALU_AND  = 4'd3,
    ALU_OR   = 4'd4,
    ALU_NOR  = 4'd5,
    ALU_SLT  = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8
  } alu_op_t;

  // Decoded control for one instruction. All-zero is a NOP.
  typedef struct packed {
    alu_op_t alu_op;
    logic    alu_src_imm;  // ALU operand b is the extended immediate
    logic    imm_zext;     // zero- rather than sign-extend the immediate
    logic    dst_rd;       // destination register is rd (else rt)
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    branch;       // beq: taken when the ALU difference is zero
  } ctrl_t;

endpackage

// File: rtl/mips_alu.sv
// ---------------------------------------------------------------------------
// mips_alu
//   Purely combinational 32-bit ALU for the MIPS subset core.
//
//   Ports
//     a_i       in  32  operand a (rs value)
//     b_i       in  32  operand b (rt value or extended immediate)
//     shamt_i   in   5  shift amount for sll/srl (applied to b_i)
//     alu_op_i  in   -  operation select (mips_pkg::alu_op_t)
//     result_o  out 32  result; 0 for ALU_ZERO and unused encodings
//     zero_o    out  1  result_o == 0
// ---------------------------------------------------------------------------
module mips_alu
  import mips_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [4:0]  shamt_i,
  input  alu_op_t     alu_op_i,
  output logic [31:0] result_o,
  output logic        zero_o
);

  // NOTE: a default assignment ahead of the case keeps every path driven,
  // so no latch is inferred for result_o.
  always_comb begin
    result_o = '0;
    case (alu_op_i)
      ALU_ADD: result_o = a_i + b_i;
      ALU_SUB: result_o = a_i - b_i;
      ALU_AND: result_o = a_i & b_i;
      ALU_OR:  result_o = a_i | b_i;
      ALU_NOR: result_o = ~(a_i | b_i);
      ALU_SLT: result_o = {31'd0, ($signed(a_i) < $signed(b_i))};
      ALU_SLL: result_o = b_i << shamt_i;
      ALU_SRL: result_o = b_i >> shamt_i;
      default: result_o = '0;
    endcase
  end

  assign zero_o = (result_o == 32'd0);

endmodule

// File: rtl/mips_alu_core.sv
// ---------------------------------------------------------------------------
// mips_alu_core
//   Single-cycle MIPS-I integer subset core: instruction ROM, 32x32 register
//   file, ALU (mips_alu) and data RAM. One instruction retires on every
//   rising clock edge; register write, RAM write and PC update share that
//   edge. Supported: add sub and or nor slt addi andi ori lw sw beq.
//   Anything else is a NOP (PC+4, no writes, ALU result 0).
//
//   Optional feature macro: MIPS_SHIFT_EN
//     defined   : sll (funct 0x00) and srl (funct 0x02) are decoded.
//                 32'h0 stays a NOP because writes to $0 are dropped.
//     undefined : funct 0x00/0x02 decode as unknown -> NOP.
//
//   Parameters
//     IMEM_DEPTH  instruction words (power of two); index = pc[log2+1:2]
//     DMEM_DEPTH  data words (power of two); index = addr[log2+1:2]
//     IMEM_FILE   name of the ROM image the environment loads into
//                 imem_rom at time 0; unloaded words read as 0 (NOP)
//
//   Ports
//     clock         in   1  sole clock, rising edge active
//     reset_n       in   1  asynchronous active-low reset
//     pc_o          out 32  PC of the instruction currently executing
//     instr_o       out 32  instruction word at pc_o
//     alu_result_o  out 32  combinational ALU result of that instruction
//     zero_o        out  1  alu_result_o == 0
// ---------------------------------------------------------------------------
module mips_alu_core
  import mips_pkg::*;
#(
  parameter int    IMEM_DEPTH = 64,
  parameter int    DMEM_DEPTH = 64,
  parameter string IMEM_FILE  = "imem.hex"
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic [31:0] pc_o,
  output logic [31:0] instr_o,
  output logic [31:0] alu_result_o,
  output logic        zero_o
);

  localparam int          IAW     = $clog2(IMEM_DEPTH);
  localparam int          DAW     = $clog2(DMEM_DEPTH);
  // PC wraps modulo the instruction space in bytes.
  localparam logic [31:0] PC_MASK = 32'(IMEM_DEPTH * 4 - 1);

  // -------------------------------------------------------------------------
  // Storage
  // -------------------------------------------------------------------------
  logic [31:0] imem_rom [IMEM_DEPTH];
  logic [31:0] dmem_q   [DMEM_DEPTH];
  logic [31:0] rf_q     [32];
  logic [31:0] pc_q;
  logic [31:0] pc_d;

  // -------------------------------------------------------------------------
  // Fetch and field extraction
  // -------------------------------------------------------------------------
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [15:0] imm;

  assign instr  = imem_rom[pc_q[IAW+1:2]];
  assign opcode = instr[31:26];
  assign rs     = instr[25:21];
  assign rt     = instr[20:16];
  assign rd     = instr[15:11];
  assign shamt  = instr[10:6];
  assign funct  = instr[5:0];
  assign imm    = instr[15:0];

  // -------------------------------------------------------------------------
  // Decode
  // -------------------------------------------------------------------------
  ctrl_t ctrl;

  always_comb begin
    ctrl = '0;
    case (opcode)
      OP_RTYPE: begin
        ctrl.dst_rd    = 1'b1;
        ctrl.reg_write = 1'b1;
        case (funct)
          FN_ADD: ctrl.alu_op = ALU_ADD;
          FN_SUB: ctrl.alu_op = ALU_SUB;
          FN_AND: ctrl.alu_op = ALU_AND;
          FN_OR:  ctrl.alu_op = ALU_OR;
          FN_NOR: ctrl.alu_op = ALU_NOR;
          FN_SLT: ctrl.alu_op = ALU_SLT;
`ifdef MIPS_SHIFT_EN
          FN_SLL: ctrl.alu_op = ALU_SLL;
          FN_SRL: ctrl.alu_op = ALU_SRL;
`endif
          // Unknown funct: suppress the write; alu_op stays ALU_ZERO.
          default: ctrl.reg_write = 1'b0;
        endcase
      end
      OP_ADDI: begin
        ctrl.alu_op      = ALU_ADD;
        ctrl.alu_src_imm = 1'b1;
        ctrl.reg_write   = 1'b1;
      end
      OP_ANDI: begin
        ctrl.alu_op      = ALU_AND;
        ctrl.alu_src_imm = 1'b1;
        ctrl.imm_zext    = 1'b1;
        ctrl.reg_write   = 1'b1;
      end
      OP_ORI: begin
        ctrl.alu_op      = ALU_OR;
        ctrl.alu_src_imm = 1'b1;
        ctrl.imm_zext    = 1'b1;
        ctrl.reg_write   = 1'b1;
      end
      OP_LW: begin
        ctrl.alu_op      = ALU_ADD;
        ctrl.alu_src_imm = 1'b1;
        ctrl.mem_read    = 1'b1;
        ctrl.reg_write   = 1'b1;
      end
      OP_SW: begin
        ctrl.alu_op      = ALU_ADD;
        ctrl.alu_src_imm = 1'b1;
        ctrl.mem_write   = 1'b1;
      end
      OP_BEQ: begin
        ctrl.alu_op = ALU_SUB;
        ctrl.branch = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

  // -------------------------------------------------------------------------
  // Execute
  // -------------------------------------------------------------------------
  logic [31:0]    rs_val;
  logic [31:0]    rt_val;
  logic [31:0]    imm_ext;
  logic [31:0]    alu_b;
  logic [31:0]    alu_result;
  logic           alu_zero;
  logic [DAW-1:0] dmem_idx;
  logic [31:0]    wb_data;
  logic [4:0]     wb_addr;
  logic           branch_taken;
  logic [31:0]    pc_plus4;
  logic [31:0]    br_target;

  // Asynchronous reads of the state at the start of the cycle, so a
  // same-cycle write to the same register is only seen next cycle.
  // rf_q[0] is cleared by reset and never written, so $0 always reads 0.
  assign rs_val  = rf_q[rs];
  assign rt_val  = rf_q[rt];

  assign imm_ext = ctrl.imm_zext ? {16'h0000, imm} : {{16{imm[15]}}, imm};
  assign alu_b   = ctrl.alu_src_imm ? imm_ext : rt_val;

  mips_alu u_alu (
    .a_i      (rs_val),
    .b_i      (alu_b),
    .shamt_i  (shamt),
    .alu_op_i (ctrl.alu_op),
    .result_o (alu_result),
    .zero_o   (alu_zero)
  );

  // Byte-offset bits are dropped and high bits wrap modulo DMEM_DEPTH.
  assign dmem_idx     = alu_result[DAW+1:2];
  assign wb_data      = ctrl.mem_read ? dmem_q[dmem_idx] : alu_result;
  assign wb_addr      = ctrl.dst_rd ? rd : rt;

  assign branch_taken = ctrl.branch & alu_zero;
  assign pc_plus4     = pc_q + 32'd4;
  assign br_target    = pc_plus4 + {imm_ext[29:0], 2'b00};
  assign pc_d         = (branch_taken ? br_target : pc_plus4) & PC_MASK;

  // -------------------------------------------------------------------------
  // State update
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, which is what gives the single-cycle
  // read-old/write-new behaviour.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc_q <= '0;
      for (int i = 0; i < 32; i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      pc_q <= pc_d;
      if (ctrl.reg_write && (wb_addr != 5'd0)) begin
        rf_q[wb_addr] <= wb_data;
      end
    end
  end

  // NOTE: data RAM has no reset so it maps onto plain memory; the reset_n
  // term only blocks a store from an instruction aborted by reset.
  always_ff @(posedge clock) begin
    if (reset_n && ctrl.mem_write) begin
      dmem_q[dmem_idx] <= rt_val;
    end
  end

  // -------------------------------------------------------------------------
  // Debug outputs
  // -------------------------------------------------------------------------
  assign pc_o         = pc_q;
  assign instr_o      = instr;
  assign alu_result_o = alu_result;
  assign zero_o       = alu_zero;

endmodule

// File: tb/tb_mips_alu_core.sv
// ---------------------------------------------------------------------------
// tb_mips_alu_core
//   Loads small programs into the core's instruction ROM, runs them, and
//   compares pc_o / instr_o / alu_result_o / zero_o every cycle against an
//   instruction-set-level interpreter. Register contents are observed by
//   executing "or $10,$r,$0" and reading the ALU result.
// ---------------------------------------------------------------------------
module tb_mips_alu_core;

  localparam int IWORDS = 64;
  localparam int DWORDS = 64;
  localparam int IBYTES = IWORDS * 4;

  // Instruction encodings
  localparam logic [5:0] O_R    = 6'h00, O_BEQ = 6'h04, O_ADDI = 6'h08,
                         O_ANDI = 6'h0C, O_ORI = 6'h0D, O_LW   = 6'h23,
                         O_SW   = 6'h2B;
  localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_ADD = 6'h20,
                         F_SUB = 6'h22, F_AND = 6'h24, F_OR  = 6'h25,
                         F_NOR = 6'h27, F_SLT = 6'h2A;

  logic        clock;
  logic        reset_n;
  logic [31:0] pc_o;
  logic [31:0] instr_o;
  logic [31:0] alu_result_o;
  logic        zero_o;

  mips_alu_core #(
    .IMEM_DEPTH (IWORDS),
    .DMEM_DEPTH (DWORDS)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .pc_o         (pc_o),
    .instr_o      (instr_o),
    .alu_result_o (alu_result_o),
    .zero_o       (zero_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // -------------------------------------------------------------------------
  // Program image and reference machine state
  // -------------------------------------------------------------------------
  logic [31:0] prog   [IWORDS];
  logic [31:0] m_regs [32];
  logic [31:0] m_dmem [DWORDS];
  logic [31:0] m_pc;

  function automatic logic [31:0] rtype(input logic [5:0] fn, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] rd,
                                        input logic [4:0] sh);
    return {O_R, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic bit r_known(input logic [5:0] fn);
    bit k;
    k = (fn == F_ADD) || (fn == F_SUB) || (fn == F_AND) || (fn == F_OR) ||
        (fn == F_NOR) || (fn == F_SLT);
`ifdef MIPS_SHIFT_EN
    k = k || (fn == F_SLL) || (fn == F_SRL);
`endif
    return k;
  endfunction

  // Architectural ALU value of an instruction given the current registers.
  function automatic logic [31:0] ref_alu(input logic [31:0] ins);
    logic [31:0] a, b, se, ze;
    a  = m_regs[ins[25:21]];
    b  = m_regs[ins[20:16]];
    se = {{16{ins[15]}}, ins[15:0]};
    ze = {16'h0000, ins[15:0]};
    case (ins[31:26])
      O_R: begin
        if (!r_known(ins[5:0])) return 32'd0;
        case (ins[5:0])
          F_ADD:   return a + b;
          F_SUB:   return a - b;
          F_AND:   return a & b;
          F_OR:    return a | b;
          F_NOR:   return ~(a | b);
          F_SLT:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          F_SLL:   return b << ins[10:6];
          F_SRL:   return b >> ins[10:6];
          default: return 32'd0;
        endcase
      end
      O_ADDI:      return a + se;
      O_ANDI:      return a & ze;
      O_ORI:       return a | ze;
      O_LW, O_SW:  return a + se;
      O_BEQ:       return a - b;
      default:     return 32'd0;
    endcase
  endfunction

  task automatic wr_reg(input logic [4:0] r, input logic [31:0] v);
    if (r != 5'd0) m_regs[r] = v;
  endtask

  // Retire one instruction in the reference machine.
  task automatic model_step();
    logic [31:0] ins, res, nxt;
    int          didx;
    ins  = prog[m_pc[7:2]];
    res  = ref_alu(ins);
    didx = int'((res >> 2) % DWORDS);
    nxt  = m_pc + 32'd4;
    case (ins[31:26])
      O_R:                  if (r_known(ins[5:0])) wr_reg(ins[15:11], res);
      O_ADDI, O_ANDI, O_ORI: wr_reg(ins[20:16], res);
      O_LW:                 wr_reg(ins[20:16], m_dmem[didx]);
      O_SW:                 m_dmem[didx] = m_regs[ins[20:16]];
      O_BEQ: if (m_regs[ins[25:21]] == m_regs[ins[20:16]])
               nxt = nxt + ({{16{ins[15]}}, ins[15:0]} << 2);
      default: ;
    endcase
    m_pc = nxt % IBYTES;
  endtask

  // Called at a falling edge: compare the current instruction's outputs,
  // advance the model, and wait for the next falling edge.
  task automatic tick();
    logic [31:0] ins, exp;
    ins = prog[m_pc[7:2]];
    exp = ref_alu(ins);
    check("pc", pc_o, m_pc);
    check("instr", instr_o, ins);
    check("alu", alu_result_o, exp);
    check("zero", 32'(zero_o), 32'(exp == 32'd0));
    model_step();
    @(negedge clock);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_prog();
    for (int i = 0; i < IWORDS; i++) prog[i] = 32'h0;
  endtask

  // Load prog, hold reset across two rising edges, release at a falling edge.
  task automatic start_prog();
    reset_n = 1'b0;
    for (int i = 0; i < IWORDS; i++) dut.imem_rom[i] = prog[i];
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_pc = 32'd0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("reset_pc", pc_o, 32'd0);
    check("reset_instr", instr_o, prog[0]);
    reset_n = 1'b1;
  endtask

  // Assert reset between edges; it must act before the next rising edge.
  task automatic mid_reset();
    #2 reset_n = 1'b0;
    #1;
    check("midrst_pc", pc_o, 32'd0);
    check("midrst_instr", instr_o, prog[0]);
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_pc = 32'd0;
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0]  a, b, c, sh;
    logic [15:0] imm;
    a   = 5'($urandom_range(0, 7));
    b   = 5'($urandom_range(0, 7));
    c   = 5'($urandom_range(0, 7));
    sh  = 5'($urandom_range(0, 31));
    imm = 16'($urandom);
    case ($urandom_range(0, 14))
      0:  return rtype(F_ADD, a, b, c, 5'd0);
      1:  return rtype(F_SUB, a, b, c, 5'd0);
      2:  return rtype(F_AND, a, b, c, 5'd0);
      3:  return rtype(F_OR,  a, b, c, 5'd0);
      4:  return rtype(F_NOR, a, b, c, 5'd0);
      5:  return rtype(F_SLT, a, b, c, 5'd0);
      6:  return rtype(F_SLL, 5'd0, b, c, sh);
      7:  return rtype(F_SRL, 5'd0, b, c, sh);
      8:  return itype(O_ADDI, a, b, imm);
      9:  return itype(O_ANDI, a, b, imm);
      10: return itype(O_ORI,  a, b, imm);
      11: return itype(O_LW,   a, b, imm);
      12: return itype(O_SW,   a, b, imm);
      13: return itype(O_BEQ,  a, b, 16'($urandom_range(0, 6)) - 16'd3);
      default: return itype(6'h3F, a, b, imm);
    endcase
  endfunction

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  initial begin
    reset_n = 1'b0;
    for (int i = 0; i < DWORDS; i++) m_dmem[i] = 32'd0;

    // Reset holds off writes; PC wraps; mid-cycle reset clears registers.
    clear_prog();
    prog[0] = itype(O_ADDI, 5'd1, 5'd1, 16'd5);
    prog[1] = rtype(F_OR, 5'd1, 5'd0, 5'd10, 5'd0);
    start_prog();
    tick();
    check("reset_nowrite", alu_result_o, 32'd5);
    ticks(63);
    check("pc_wrap", pc_o, 32'd0);
    ticks(2);
    mid_reset();
    tick();
    check("midrst_regs", alu_result_o, 32'd5);

    // Arithmetic
    clear_prog();
    prog[0] = itype(O_ADDI, 5'd0, 5'd1, 16'd5);
    prog[1] = itype(O_ADDI, 5'd0, 5'd2, 16'hFFFD);
    prog[2] = rtype(F_ADD, 5'd1, 5'd2, 5'd3, 5'd0);
    prog[3] = rtype(F_SUB, 5'd2, 5'd1, 5'd4, 5'd0);
    prog[4] = rtype(F_SLT, 5'd2, 5'd1, 5'd5, 5'd0);
    prog[5] = rtype(F_OR, 5'd3, 5'd0, 5'd10, 5'd0);
    prog[6] = rtype(F_OR, 5'd4, 5'd0, 5'd10, 5'd0);
    prog[7] = rtype(F_OR, 5'd5, 5'd0, 5'd10, 5'd0);
    start_prog();
    ticks(5);
    check("add_r3", alu_result_o, 32'd2);
    tick();
    check("sub_r4", alu_result_o, 32'hFFFF_FFF8);
    tick();
    check("slt_r5", alu_result_o, 32'd1);
    ticks(2);

    // Logic, $0 immutability, zero-extension, unknown encodings
    clear_prog();
    prog[0]  = itype(O_ORI,  5'd0, 5'd1, 16'hF0F0);
    prog[1]  = itype(O_ANDI, 5'd1, 5'd2, 16'h00FF);
    prog[2]  = rtype(F_NOR, 5'd1, 5'd0, 5'd3, 5'd0);
    prog[3]  = rtype(F_ADD, 5'd1, 5'd1, 5'd0, 5'd0);
    prog[4]  = rtype(F_OR, 5'd2, 5'd0, 5'd10, 5'd0);
    prog[5]  = rtype(F_OR, 5'd3, 5'd0, 5'd10, 5'd0);
    prog[6]  = rtype(F_OR, 5'd0, 5'd0, 5'd10, 5'd0);
    prog[7]  = itype(O_ORI, 5'd0, 5'd6, 16'h8000);
    prog[8]  = itype(6'h3F, 5'd1, 5'd7, 16'h1234);
    prog[9]  = rtype(F_OR, 5'd7, 5'd0, 5'd10, 5'd0);
    prog[10] = rtype(6'h21, 5'd1, 5'd1, 5'd8, 5'd0);
    prog[11] = rtype(F_OR, 5'd8, 5'd0, 5'd10, 5'd0);
    start_prog();
    ticks(4);
    check("andi_r2", alu_result_o, 32'h0000_00F0);
    tick();
    check("nor_r3", alu_result_o, 32'hFFFF_0F0F);
    tick();
    check("r0_alu", alu_result_o, 32'd0);
    check("r0_zero", 32'(zero_o), 32'd1);
    tick();
    check("ori_zext", alu_result_o, 32'h0000_8000);
    tick();
    check("unk_op_alu", alu_result_o, 32'd0);
    tick();
    check("unk_op_nowr", alu_result_o, 32'd0);
    tick();
    check("unk_fn_alu", alu_result_o, 32'd0);
    tick();
    check("unk_fn_nowr", alu_result_o, 32'd0);
    ticks(2);

    // Memory, including ignored low bits and address wrap
    clear_prog();
    prog[0] = itype(O_ADDI, 5'd0, 5'd1, 16'h1234);
    prog[1] = itype(O_SW,   5'd0, 5'd1, 16'd8);
    prog[2] = itype(O_LW,   5'd0, 5'd2, 16'd8);
    prog[3] = rtype(F_OR, 5'd2, 5'd0, 5'd10, 5'd0);
    prog[4] = itype(O_ADDI, 5'd0, 5'd4, 16'h0055);
    prog[5] = itype(O_ADDI, 5'd0, 5'd3, 16'h010A);
    prog[6] = itype(O_SW,   5'd3, 5'd4, 16'd0);
    prog[7] = itype(O_LW,   5'd0, 5'd5, 16'd8);
    prog[8] = rtype(F_OR, 5'd5, 5'd0, 5'd10, 5'd0);
    start_prog();
    ticks(3);
    check("lw_r2", alu_result_o, 32'h0000_1234);
    ticks(5);
    check("lw_wrap", alu_result_o, 32'h0000_0055);
    ticks(2);

    // Branch taken at 0x10
    clear_prog();
    prog[0] = itype(O_ADDI, 5'd0, 5'd1, 16'd7);
    prog[4] = itype(O_BEQ, 5'd0, 5'd0, 16'd2);
    start_prog();
    ticks(4);
    check("beq_at", pc_o, 32'h10);
    tick();
    check("beq_taken", pc_o, 32'h1C);
    ticks(2);

    // Branch not taken at 0x10
    prog[4] = itype(O_BEQ, 5'd1, 5'd0, 16'd2);
    start_prog();
    ticks(4);
    check("beq_nt_zero", 32'(zero_o), 32'd0);
    tick();
    check("beq_nt_pc", pc_o, 32'h14);

    // Shifts (NOPs when the feature is absent)
    clear_prog();
    prog[0] = itype(O_ADDI, 5'd0, 5'd1, 16'd3);
    prog[1] = rtype(F_SLL, 5'd0, 5'd1, 5'd2, 5'd4);
    prog[2] = rtype(F_OR, 5'd2, 5'd0, 5'd10, 5'd0);
    prog[3] = rtype(F_SRL, 5'd0, 5'd2, 5'd3, 5'd2);
    prog[4] = 32'h0;
    start_prog();
    ticks(2);
`ifdef MIPS_SHIFT_EN
    check("sll_r2", alu_result_o, 32'd48);
    tick();
    check("srl_alu", alu_result_o, 32'd12);
`else
    check("sll_off_r2", alu_result_o, 32'd0);
    tick();
    check("srl_off_alu", alu_result_o, 32'd0);
`endif
    tick();
    check("nop_alu", alu_result_o, 32'd0);
    ticks(2);

    // Randomized programs with a reset in the middle of each run
    for (int s = 0; s < 4; s++) begin
      for (int i = 0; i < IWORDS; i++) prog[i] = rand_instr();
      start_prog();
      ticks(75);
      mid_reset();
      ticks(75);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
